// File: rtl/capture_gray_pkg.sv
// Shared types and gray weights for capture_gray_pipeline.
// GRAY_WEIGHTED_EN selects BT.601 weights instead of the (R + 2G + B) / 4 approximation.
package capture_gray_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    GRAY    = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

`ifdef GRAY_WEIGHTED_EN
  localparam logic [7:0] GRAY_WR    = 8'd77;
  localparam logic [7:0] GRAY_WG    = 8'd150;
  localparam logic [7:0] GRAY_WB    = 8'd29;
  localparam int         GRAY_SHIFT = 8;
`else
  localparam logic [7:0] GRAY_WR    = 8'd1;
  localparam logic [7:0] GRAY_WG    = 8'd2;
  localparam logic [7:0] GRAY_WB    = 8'd1;
  localparam int         GRAY_SHIFT = 2;
`endif

  localparam logic [7:0] GRAY_MAX = 8'd255;

  function automatic logic [7:0] gray_y(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
    logic [17:0] acc;
    acc = (18'(GRAY_WR) * 18'(r) + 18'(GRAY_WG) * 18'(g) + 18'(GRAY_WB) * 18'(b)) >> GRAY_SHIFT;
    if (acc > 18'(GRAY_MAX)) begin
      gray_y = GRAY_MAX;
    end else begin
      gray_y = acc[7:0];
    end
  endfunction

endpackage

// File: rtl/capture_gray_pipeline_frame_buffer.sv
// RGB byte frame buffer: single-port-per-direction sync RAM with one write and one read pointer.
// Each pointer wraps after the last address; the read side then stays stopped until read mode drops.
module frame_buffer #(
  parameter int DEPTH = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       wr_mode,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  input  logic       rd_mode,
  input  logic       pause,
  output logic       buf_done,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic          rd_done_r;
  logic          rd_valid_r;
  logic [7:0]    rd_data_r;
  logic          wr_en_s;
  logic          wr_last_s;
  logic          rd_en_s;
  logic          rd_last_s;

  // Access enables; clear blocks both sides for the cycle it resets the pointers.
  always_comb begin
    wr_en_s   = wr_mode && wr_valid && !clear;
    wr_last_s = (wptr_r == LAST_ADDR);
    rd_en_s   = rd_mode && !pause && !rd_done_r && !clear;
    rd_last_s = (rptr_r == LAST_ADDR);
    buf_done  = wr_en_s && wr_last_s;
  end

  // Pointer, read-done flag and read-valid pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      rd_done_r  <= 1'b0;
      rd_valid_r <= 1'b0;
    end else if (clear) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      rd_done_r  <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wptr_r <= wr_last_s ? '0 : wptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rptr_r    <= rd_last_s ? '0 : rptr_r + AW'(1);
        rd_done_r <= rd_last_s;
      end else if (!rd_mode) begin
        rd_done_r <= 1'b0;
      end
      rd_valid_r <= rd_en_s;
    end
  end

  // Storage array and registered read port (contents are not reset).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wptr_r] <= wr_data;
    end
    if (rd_en_s) begin
      rd_data_r <= mem_r[rptr_r];
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: rtl/capture_gray_pipeline.sv
// Keypoint front end: sequencing FSM, RGB frame buffer and grayscaler.
// Build option GRAY_WEIGHTED_EN (see capture_gray_pkg) selects the luma weights.
module capture_gray_pipeline
  import capture_gray_pkg::*;
#(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clear,
  input  logic       cam_valid,
  input  logic [7:0] cam_data,
  input  logic       rwm2_done,
  output logic       camera_en,
  output logic       rwm2_en,
  output logic       rwm2_rw,
  output logic [7:0] gs_data,
  output logic       gs_valid,
  output logic       busy
);

  localparam int DEPTH = 3 * IMG_W * IMG_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int PW    = $clog2(NPIX + 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);

  state_t        state_r;
  state_t        state_next_s;
  logic          camera_en_s, rwm2_en_s, rwm2_rw_s, busy_s;
  logic          camera_en_r, rwm2_en_r, rwm2_rw_r, busy_r;
  logic          buf_done_s;
  logic [7:0]    rd_data_s;
  logic          rd_valid_s;
  logic          pause_s;
  logic [1:0]    phase_r;
  logic [7:0]    r_byte_r;
  logic [7:0]    g_byte_r;
  logic [PW-1:0] px_cnt_r;
  logic [7:0]    gs_data_r;
  logic          gs_valid_r;
  logic          gs_done_r;

  frame_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_frame_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .wr_mode  (state_r == CAPTURE),
    .wr_valid (cam_valid),
    .wr_data  (cam_data),
    .rd_mode  (state_r == GRAY),
    .pause    (pause_s),
    .buf_done (buf_done_s),
    .rd_data  (rd_data_s),
    .rd_valid (rd_valid_s)
  );

  // The cycle a pixel is emitted also stalls the read side, giving a 4-cycle pixel cadence.
  assign pause_s = gs_valid_r;

  // Next-state logic and output decode of the state being entered.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = CAPTURE;
        else       state_next_s = IDLE;
      end
      CAPTURE: begin
        if (buf_done_s) state_next_s = GRAY;
        else            state_next_s = CAPTURE;
      end
      GRAY: begin
        if (gs_done_r) state_next_s = OUTPUT;
        else           state_next_s = GRAY;
      end
      OUTPUT: begin
        if (rwm2_done) state_next_s = IDLE;
        else           state_next_s = OUTPUT;
      end
      default: state_next_s = IDLE;
    endcase
    camera_en_s = (state_next_s == CAPTURE);
    rwm2_en_s   = (state_next_s == GRAY) || (state_next_s == OUTPUT);
    rwm2_rw_s   = (state_next_s == OUTPUT) ? RW_READ : RW_WRITE;
    busy_s      = (state_next_s != IDLE);
  end

  // State register with outputs registered alongside so they always match the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      camera_en_r <= 1'b0;
      rwm2_en_r   <= 1'b0;
      rwm2_rw_r   <= RW_WRITE;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      camera_en_r <= camera_en_s;
      rwm2_en_r   <= rwm2_en_s;
      rwm2_rw_r   <= rwm2_rw_s;
      busy_r      <= busy_s;
    end
  end

  // Grayscaler: collect R, G, B by byte phase, emit Y one cycle after the B byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r    <= 2'd0;
      r_byte_r   <= 8'd0;
      g_byte_r   <= 8'd0;
      px_cnt_r   <= '0;
      gs_data_r  <= 8'd0;
      gs_valid_r <= 1'b0;
      gs_done_r  <= 1'b0;
    end else if (clear) begin
      phase_r    <= 2'd0;
      px_cnt_r   <= '0;
      gs_valid_r <= 1'b0;
      gs_done_r  <= 1'b0;
    end else if (rd_valid_s && (state_r == GRAY)) begin
      case (phase_r)
        2'd0: begin
          r_byte_r   <= rd_data_s;
          phase_r    <= 2'd1;
          gs_valid_r <= 1'b0;
          gs_done_r  <= 1'b0;
        end
        2'd1: begin
          g_byte_r   <= rd_data_s;
          phase_r    <= 2'd2;
          gs_valid_r <= 1'b0;
          gs_done_r  <= 1'b0;
        end
        2'd2: begin
          gs_data_r  <= gray_y(r_byte_r, g_byte_r, rd_data_s);
          gs_valid_r <= 1'b1;
          phase_r    <= 2'd0;
          gs_done_r  <= (px_cnt_r == LAST_PIX);
          px_cnt_r   <= (px_cnt_r == LAST_PIX) ? '0 : px_cnt_r + PW'(1);
        end
        default: begin
          phase_r    <= 2'd0;
          gs_valid_r <= 1'b0;
          gs_done_r  <= 1'b0;
        end
      endcase
    end else begin
      gs_valid_r <= 1'b0;
      gs_done_r  <= 1'b0;
    end
  end

  assign camera_en = camera_en_r;
  assign rwm2_en   = rwm2_en_r;
  assign rwm2_rw   = rwm2_rw_r;
  assign busy      = busy_r;
  assign gs_data   = gs_data_r;
  assign gs_valid  = gs_valid_r;

endmodule

// File: tb/tb_capture_gray_pipeline.sv
// Self-checking bench for capture_gray_pipeline with a 4x2 frame (24 bytes).
// Random frames are checked against a pixel-level gray model computed from the luma formula.
module tb_capture_gray_pipeline;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int DEPTH = 3 * NPIX;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       clear;
  logic       cam_valid;
  logic [7:0] cam_data;
  logic       rwm2_done;
  logic       camera_en;
  logic       rwm2_en;
  logic       rwm2_rw;
  logic [7:0] gs_data;
  logic       gs_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int frame_bytes [DEPTH];
  int exp_q [$];
  int last_gray = 0;

  capture_gray_pipeline #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .cam_valid (cam_valid),
    .cam_data  (cam_data),
    .rwm2_done (rwm2_done),
    .camera_en (camera_en),
    .rwm2_en   (rwm2_en),
    .rwm2_rw   (rwm2_rw),
    .gs_data   (gs_data),
    .gs_valid  (gs_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_gray(input int r, input int g, input int b);
    int y;
`ifdef GRAY_WEIGHTED_EN
    y = (77 * r + 150 * g + 29 * b) / 256;
`else
    y = (r + 2 * g + b) / 4;
`endif
    if (y > 255) y = 255;
    return y;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Build a frame; with special=1 the first two pixels are the fixed corner cases.
  task automatic fill_frame(input bit special);
    for (int i = 0; i < DEPTH; i++) frame_bytes[i] = int'($urandom_range(0, 255));
    if (special) begin
      frame_bytes[0] = 255; frame_bytes[1] = 255; frame_bytes[2] = 255;
      frame_bytes[3] = 100; frame_bytes[4] = 50;  frame_bytes[5] = 200;
    end
    exp_q.delete();
    for (int p = 0; p < NPIX; p++)
      exp_q.push_back(ref_gray(frame_bytes[3*p], frame_bytes[3*p+1], frame_bytes[3*p+2]));
  endtask

  // Stream the frame with random gaps, then offer one surplus byte.
  task automatic feed_frame();
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cam_valid = 1'b0;
        @(negedge clk);
        check("camera_en_gap", 32'(camera_en), 32'd1);
      end
      cam_valid = 1'b1;
      cam_data  = 8'(frame_bytes[i]);
      @(negedge clk);
      if (i == DEPTH - 1) begin
        check("camera_en_after_last", 32'(camera_en), 32'd0);
        check("busy_after_last", 32'(busy), 32'd1);
      end else begin
        check("camera_en_mid", 32'(camera_en), 32'd1);
      end
    end
    cam_valid = 1'b1;
    cam_data  = 8'hEE;
  endtask

  // Watch the gray phase until the FSM reports the read direction.
  task automatic watch_gray();
    int  npulse;
    int  last_cyc;
    int  pulse8_cyc;
    bit  done;
    npulse     = 0;
    last_cyc   = 0;
    pulse8_cyc = -100;
    done       = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (rwm2_rw === 1'b1) begin
        done = 1'b1;
        check("gs_done_to_output", 32'(cyc), 32'(pulse8_cyc + 1));
        check("gs_valid_in_output", 32'(gs_valid), 32'd0);
      end else begin
        check("gray_rwm2_en", 32'(rwm2_en), 32'd1);
        check("gray_camera_en", 32'(camera_en), 32'd0);
        if (gs_valid === 1'b1) begin
          if (npulse == 0) check("first_pixel_latency", 32'(cyc), 32'd4);
          else             check("pixel_spacing", 32'(cyc - last_cyc), 32'd4);
          if (exp_q.size() > 0) begin
            last_gray = exp_q.pop_front();
            check("gs_data", 32'(gs_data), 32'(last_gray));
          end else begin
            check("pulse_count_live", 32'(npulse + 1), 32'(NPIX));
          end
          last_cyc = cyc;
          npulse++;
          if (npulse == NPIX) pulse8_cyc = cyc;
        end
        start = (cyc == 2) ? 1'b1 : 1'b0;
        @(negedge clk);
        cam_valid = 1'b0;
      end
    end
    start = 1'b0;
    check("gray_completed", 32'(done), 32'd1);
    check("pulse_count", 32'(npulse), 32'(NPIX));
  endtask

  // Hold OUTPUT a few cycles (with an ignored start), then release it with rwm2_done.
  task automatic finish_output();
    int n;
    n = int'($urandom_range(2, 5));
    for (int k = 0; k < n; k++) begin
      check("out_busy", 32'(busy), 32'd1);
      check("out_rwm2_en", 32'(rwm2_en), 32'd1);
      check("out_rwm2_rw", 32'(rwm2_rw), 32'd1);
      check("out_camera_en", 32'(camera_en), 32'd0);
      check("out_gs_valid", 32'(gs_valid), 32'd0);
      start = (k == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start     = 1'b0;
    rwm2_done = 1'b1;
    @(negedge clk);
    rwm2_done = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rwm2_en", 32'(rwm2_en), 32'd0);
    check("idle_rwm2_rw", 32'(rwm2_rw), 32'd0);
    check("idle_camera_en", 32'(camera_en), 32'd0);
    check("gs_data_hold", 32'(gs_data), 32'(last_gray));
  endtask

  task automatic start_pulse(input bit with_clear);
    start = 1'b1;
    clear = with_clear;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_camera_en", 32'(camera_en), 32'd1);
    check("start_rwm2_en", 32'(rwm2_en), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    clear     = 1'b0;
    cam_valid = 1'b0;
    cam_data  = 8'd0;
    rwm2_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_camera_en", 32'(camera_en), 32'd0);
    check("rst_rwm2_en", 32'(rwm2_en), 32'd0);
    check("rst_rwm2_rw", 32'(rwm2_rw), 32'd0);
    check("rst_gs_data", 32'(gs_data), 32'd0);
    check("rst_gs_valid", 32'(gs_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("idle_no_start", 32'(busy), 32'd0);
    end

    // Frame 1: fixed corner pixels then random
    fill_frame(1'b1);
    start_pulse(1'b0);
    feed_frame();
    watch_gray();
    finish_output();

    // Frame 2: buffer reused from address 0
    fill_frame(1'b0);
    start_pulse(1'b0);
    feed_frame();
    watch_gray();
    finish_output();

    // Frame 3: clear after 10 bytes restarts the capture
    start_pulse(1'b0);
    for (int i = 0; i < 10; i++) begin
      cam_valid = 1'b1;
      cam_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("pre_clear_camera_en", 32'(camera_en), 32'd1);
    end
    cam_valid = 1'b0;
    clear     = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_keeps_state", 32'(camera_en), 32'd1);
    fill_frame(1'b0);
    feed_frame();
    watch_gray();
    finish_output();

    // Frame 4: start and clear together in IDLE
    fill_frame(1'b0);
    start_pulse(1'b1);
    feed_frame();
    watch_gray();
    finish_output();

    // Reset mid-capture aborts, then a full frame still works
    start_pulse(1'b0);
    for (int i = 0; i < 5; i++) begin
      cam_valid = 1'b1;
      cam_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    cam_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_camera_en", 32'(camera_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_frame(1'b0);
    start_pulse(1'b0);
    feed_frame();
    watch_gray();
    finish_output();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
